// File: rtl/trip_sequencer_if.sv
// Signal bundle between trip_sequencer and the host / per-channel trip detector bank.
// master = host/detector side driving requests and flags, slave = the sequencer.
interface trip_sequencer_if #(
    parameter int NCHAN = 4,
    parameter int HW    = 16,
    parameter int CW    = 16
);
    logic             arm;
    logic             disarm;
    logic [NCHAN-1:0] chan_tripped;
    logic [NCHAN-1:0] chan_mask;
    logic [HW-1:0]    holdoff_cycles;
    logic [3:0]       max_retries;

    logic             rf_enable;
    logic             trip_reset;
    logic             peak_clear;
    logic [2:0]       state;
    logic [3:0]       retry_count;
    logic [CW-1:0]    trip_count;
    logic [NCHAN-1:0] fault_chan;

    modport master (
        output arm, disarm, chan_tripped, chan_mask, holdoff_cycles, max_retries,
        input  rf_enable, trip_reset, peak_clear, state, retry_count, trip_count, fault_chan
    );

    modport slave (
        input  arm, disarm, chan_tripped, chan_mask, holdoff_cycles, max_retries,
        output rf_enable, trip_reset, peak_clear, state, retry_count, trip_count, fault_chan
    );
endinterface

// File: rtl/trip_sequencer.sv
// RF interlock sequencer: arms RF, drops it on masked channel trip, holds off, re-arms, locks out.
// Optional first-fault channel capture is built when TRIP_FIRST_FAULT_EN is defined.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | RF off, waiting for arm
// CLEAR   | one cycle: pulse detector trip_reset (plus peak_clear on session start)
// ARMED   | RF permitted, watching masked trip flags
// HOLDOFF | RF off, holdoff down-counter running
// LOCKOUT | retry budget exhausted, RF off until disarm or reset
module trip_sequencer #(
    parameter int NCHAN = 4,
    parameter int HW    = 16,
    parameter int CW    = 16
) (
    input logic             clk,
    input logic             reset,
    trip_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_ARMED   = 3'd2,
        ST_HOLDOFF = 3'd3,
        ST_LOCKOUT = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic          rf_enable_q, rf_enable_d;
    logic          trip_reset_q, trip_reset_d;
    logic          peak_clear_q, peak_clear_d;
    logic [3:0]    retry_q, retry_d;
    logic [CW-1:0] trip_q, trip_d;
    logic [HW-1:0] timer_q, timer_d;

    logic fault;
    logic timer_tc;
    logic retries_spent;
    logic trip_evt;
    logic session_start;

    assign fault         = |(bus.chan_tripped & bus.chan_mask);
    assign timer_tc      = (timer_q == '0);
    // >= rather than == so a budget lowered mid-session still ends in lockout
    assign retries_spent = (retry_q >= bus.max_retries);
    assign trip_evt      = !bus.disarm && (state_q == ST_ARMED) && fault;
    assign session_start = !bus.disarm && (state_q == ST_IDLE) && bus.arm;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            rf_enable_q  <= 1'b0;
            trip_reset_q <= 1'b0;
            peak_clear_q <= 1'b0;
            retry_q      <= '0;
            trip_q       <= '0;
            timer_q      <= '0;
        end else begin
            state_q      <= state_d;
            rf_enable_q  <= rf_enable_d;
            trip_reset_q <= trip_reset_d;
            peak_clear_q <= peak_clear_d;
            retry_q      <= retry_d;
            trip_q       <= trip_d;
            timer_q      <= timer_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.disarm) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:    if (bus.arm) state_d = ST_CLEAR;
                // detector flags are stale during CLEAR, so faults are not looked at here
                ST_CLEAR:   state_d = ST_ARMED;
                ST_ARMED:   if (fault) state_d = retries_spent ? ST_LOCKOUT : ST_HOLDOFF;
                ST_HOLDOFF: if (timer_tc) state_d = ST_CLEAR;
                ST_LOCKOUT: state_d = ST_LOCKOUT;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        rf_enable_d  = (state_d == ST_ARMED);
        trip_reset_d = (state_d == ST_CLEAR);
        peak_clear_d = session_start;
        retry_d      = retry_q;
        trip_d       = trip_q;
        timer_d      = timer_q;

        if (session_start) begin
            retry_d = '0;
            trip_d  = '0;
        end else if (trip_evt) begin
            if (trip_q != '1) trip_d = trip_q + 1'b1;
            if (!retries_spent) begin
                retry_d = retry_q + 4'd1;
                timer_d = bus.holdoff_cycles;
            end
        end else if (state_q == ST_HOLDOFF && !timer_tc) begin
            timer_d = timer_q - 1'b1;
        end
    end

`ifdef TRIP_FIRST_FAULT_EN
    logic [NCHAN-1:0] fault_chan_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            fault_chan_q <= '0;
        end else if (session_start) begin
            fault_chan_q <= '0;
        end else if (trip_evt && trip_q == '0) begin
            fault_chan_q <= bus.chan_tripped & bus.chan_mask;
        end
    end

    assign bus.fault_chan = fault_chan_q;
`else
    assign bus.fault_chan = '0;
`endif

    assign bus.state       = state_q;
    assign bus.rf_enable   = rf_enable_q;
    assign bus.trip_reset  = trip_reset_q;
    assign bus.peak_clear  = peak_clear_q;
    assign bus.retry_count = retry_q;
    assign bus.trip_count  = trip_q;

endmodule

// File: tb/tb_trip_sequencer.sv
// Bench for trip_sequencer: directed interlock scenarios, then random traffic against a session-level model.
module tb_trip_sequencer;
    localparam int NCHAN = 4;
    localparam int HW    = 16;
    localparam int CW    = 16;

    localparam int M_IDLE    = 0;
    localparam int M_CLEAR   = 1;
    localparam int M_ARMED   = 2;
    localparam int M_HOLDOFF = 3;
    localparam int M_LOCKOUT = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    trip_sequencer_if #(.NCHAN(NCHAN), .HW(HW), .CW(CW)) bus ();

    trip_sequencer #(.NCHAN(NCHAN), .HW(HW), .CW(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // model: what the session should look like after each edge
    int               m_st        = M_IDLE;
    int               m_retry     = 0;
    int               m_trips     = 0;
    int               m_hold_left = 0;
    bit               m_pc        = 1'b0;
    logic [NCHAN-1:0] m_fc        = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic [NCHAN-1:0] hit;
        hit  = bus.chan_tripped & bus.chan_mask;
        m_pc = 1'b0;
        if (reset) begin
            m_st = M_IDLE; m_retry = 0; m_trips = 0; m_fc = '0; m_hold_left = 0;
        end else if (bus.disarm) begin
            m_st = M_IDLE;
        end else if (m_st == M_IDLE) begin
            if (bus.arm) begin
                m_st = M_CLEAR; m_pc = 1'b1; m_retry = 0; m_trips = 0; m_fc = '0;
            end
        end else if (m_st == M_CLEAR) begin
            m_st = M_ARMED;
        end else if (m_st == M_ARMED) begin
            if (hit != '0) begin
                if (m_trips == 0) m_fc = hit;
                if (m_trips < (1 << CW) - 1) m_trips++;
                if (m_retry == int'(bus.max_retries)) begin
                    m_st = M_LOCKOUT;
                end else begin
                    m_st = M_HOLDOFF;
                    m_retry++;
                    m_hold_left = int'(bus.holdoff_cycles) + 1;
                end
            end
        end else if (m_st == M_HOLDOFF) begin
            m_hold_left--;
            if (m_hold_left == 0) m_st = M_CLEAR;
        end
    endtask

    task automatic check_all();
        logic [NCHAN-1:0] exp_fc;
`ifdef TRIP_FIRST_FAULT_EN
        exp_fc = m_fc;
`else
        exp_fc = '0;
`endif
        check("state",       32'(bus.state),       32'(m_st));
        check("rf_enable",   32'(bus.rf_enable),   32'(m_st == M_ARMED));
        check("trip_reset",  32'(bus.trip_reset),  32'(m_st == M_CLEAR));
        check("peak_clear",  32'(bus.peak_clear),  32'(m_pc));
        check("retry_count", 32'(bus.retry_count), 32'(m_retry));
        check("trip_count",  32'(bus.trip_count),  32'(m_trips));
        check("fault_chan",  32'(bus.fault_chan),  32'(exp_fc));
    endtask

    task automatic step(input bit a, input bit d, input logic [NCHAN-1:0] t);
        bus.arm          = a;
        bus.disarm       = d;
        bus.chan_tripped = t;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
    endtask

    initial begin
        bus.arm            = 1'b0;
        bus.disarm         = 1'b0;
        bus.chan_tripped   = '0;
        bus.chan_mask      = 4'b1111;
        bus.holdoff_cycles = 16'd5;
        bus.max_retries    = 4'd2;

        // reset, then arm on cycle 10
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        idle(7);
        step(1'b1, 1'b0, '0);
        check("arm_clear_state", 32'(bus.state), 32'd1);
        check("arm_peak_clear",  32'(bus.peak_clear), 32'd1);
        idle(1);
        check("arm_rf_on", 32'(bus.rf_enable), 32'd1);
        idle(3);

        // three trips with budget 2: two holdoff/re-arm cycles then lockout
        step(1'b0, 1'b0, 4'b0001);
        check("trip1_rf_off", 32'(bus.rf_enable), 32'd0);
        idle(10);
        check("rearm_retry", 32'(bus.retry_count), 32'd1);
        step(1'b0, 1'b0, 4'b0001);
        idle(10);
        step(1'b0, 1'b0, 4'b0100);
        check("lock_state", 32'(bus.state),       32'd4);
        check("lock_retry", 32'(bus.retry_count), 32'd2);
        check("lock_trips", 32'(bus.trip_count),  32'd3);
        step(1'b1, 1'b0, '0);
        idle(2);
        step(1'b0, 1'b1, '0);
        check("disarm_idle", 32'(bus.state), 32'd0);

        // masked channel does not trip, unmasked pair does
        bus.chan_mask = 4'b1110;
        step(1'b1, 1'b0, '0);
        idle(2);
        step(1'b0, 1'b0, 4'b0001);
        idle(2);
        step(1'b0, 1'b0, 4'b0110);
        idle(3);
        step(1'b0, 1'b1, '0);
        bus.chan_mask = 4'b1111;

        // disarm beats a simultaneous fault; arm+disarm in IDLE stays IDLE
        step(1'b1, 1'b0, '0);
        idle(2);
        step(1'b0, 1'b1, 4'b1000);
        idle(1);
        step(1'b1, 1'b1, '0);
        idle(2);

        // zero retry budget and zero holdoff: first trip locks out
        bus.max_retries    = 4'd0;
        bus.holdoff_cycles = 16'd0;
        step(1'b1, 1'b0, '0);
        idle(2);
        step(1'b0, 1'b0, 4'b0010);
        idle(2);
        step(1'b0, 1'b1, '0);

        // reset in the middle of HOLDOFF
        bus.max_retries    = 4'd2;
        bus.holdoff_cycles = 16'd5;
        step(1'b1, 1'b0, '0);
        idle(2);
        step(1'b0, 1'b0, 4'b0001);
        idle(2);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        check("reset_mid_holdoff", 32'(bus.state), 32'd0);
        idle(2);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            bit               a, d;
            logic [NCHAN-1:0] t;
            if (m_st == M_IDLE && $urandom_range(0, 3) == 0) begin
                bus.holdoff_cycles = HW'($urandom_range(0, 7));
                bus.max_retries    = 4'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 99) == 0) bus.chan_mask = NCHAN'($urandom);
            reset = ($urandom_range(0, 299) == 0);
            a = ($urandom_range(0, 5) == 0);
            d = ($urandom_range(0, 79) == 0);
            t = ($urandom_range(0, 5) == 0) ? NCHAN'($urandom) : '0;
            step(a, d, t);
        end
        reset = 1'b0;
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
